complex_fifo: RTL

COMPLEX_FIFO -- requirements
Module: complex_fifo

---
 rtl/complex_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/complex_fifo.sv
// Circular-buffer FIFO of complex words {re, im} with registered read data,
// count-derived status flags and optional sticky overflow/underflow flags (COMPLEX_FIFO_ERR_FLAG_EN).
module complex_fifo #(
  parameter int FLOAT_LEN = 32,
  parameter int ADDR_LEN  = 4,
  parameter int AF_LEVEL  = (1 << ADDR_LEN) - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*FLOAT_LEN-1:0] din,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [2*FLOAT_LEN-1:0] dout,
  output logic                   dout_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [ADDR_LEN:0]      count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int W     = 2 * FLOAT_LEN;
  localparam int DEPTH = 1 << ADDR_LEN;
  localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(DEPTH);
  localparam logic [ADDR_LEN:0] AF_C    = (ADDR_LEN+1)'(AF_LEVEL);

  logic [W-1:0]      mem_q [DEPTH];
  logic [ADDR_LEN:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LEN:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN:0] count_q, count_d;
  logic [W-1:0]      dout_q, dout_d;
  logic              dout_valid_q;
  logic              rd_acc, wr_acc;

  // Handshake: a read is taken when rd_en=1 and not empty; a write is taken
  // when wr_en=1 and either not full or a read frees a slot in the same cycle.
  // Taken reads present data on dout with dout_valid=1 in the next cycle.
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_C);
  assign rd_acc      = rd_en && !empty;
  assign wr_acc      = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q[ADDR_LEN-1:0]];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= rd_acc;
    end
  end

  // Storage is never reset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (wr_acc && rst) mem_q[wr_ptr_q[ADDR_LEN-1:0]] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign count      = count_q;

`ifdef COMPLEX_FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A new error in the same cycle as clr_err wins over the clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en && !wr_acc) ovf_d = 1'b1;
    if (rd_en && empty)   udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
